alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Stage directly downstream of the ALU in the 8-bit core.
- Captures one ALU result per handshake into a single-entry holding register.
- Retires the entry by writing the register file, updating the N/Z/P condition-code register, and resolving conditional branches against the current CC.
- Provides back-pressure to the ALU/issue stage when the register-file write port is busy.

Parameters:
- DATA_W, 8, ALU result / register width
- PC_W, 6, program-counter and branch-target width
- REG_AW, 3, register-file address width (8 registers)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU output valid
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_W  ALU result
- in_neg / in_zero / in_pos  in  1 each  ALU flags
- in_dest  in  REG_AW  destination register
- in_reg_we  in  1  instruction writes a register
- in_set_cc  in  1  instruction updates CC
- in_is_br  in  1  instruction is conditional branch
- in_br_mask  in  3  branch condition mask {n,z,p}
- in_br_target  in  PC_W  branch target
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts write this cycle
- cc_nzp  out  3  current condition code {n,z,p}
- br_taken  out  1  one-cycle taken pulse
- br_target  out  PC_W  target, valid with br_taken
- cc_err  out  1  sticky: ALU flags were not one-hot

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, entry discarded, rf_we=0, cc_nzp=3'b010, br_taken=0, br_target=0, cc_err=0. Reset mid-HOLD drops the entry with no RF write and no CC change.
- FSM states:
  - IDLE: entry empty.
  - HOLD: entry full.
- Accept occurs when in_valid && in_ready; all in_* fields are registered into the entry.
- retire = HOLD && (!entry.reg_we || rf_ready).
- in_ready = IDLE || retire, combinational. Throughput is 1/cycle while rf_ready=1.
- Transitions:
  - IDLE -> HOLD on accept.
  - HOLD -> HOLD on retire with simultaneous accept (new entry loaded).
  - HOLD -> HOLD while stalled (entry held unchanged).
  - HOLD -> IDLE on retire without accept.
- rf_we = HOLD && entry.reg_we, combinational from the entry. rf_waddr/rf_wdata come from the entry and stay stable while stalled. R0 is writable.
- CC update happens at retire when entry.set_cc:
  - If {n,z,p} flags are exactly one-hot, load them.
  - Otherwise derive from result: N=result[DATA_W-1]; Z=(result==0); P=neither. Also set cc_err=1, which clears only on reset.
- Branch resolution at retire when entry.is_br:
  - taken = |(entry.br_mask & cc_nzp), using the CC value before this cycle's update.
  - br_taken is registered: it pulses high for exactly one cycle in the cycle after retire, with br_target=entry.br_target.
  - Mask 3'b000 is never taken; mask 3'b111 is always taken.
- A branch entry with reg_we or set_cc also set performs those actions too. The branch still compares against the old CC.
- The stage performs no arithmetic on data; widths pass through unchanged.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- When defined, adds outputs byp_valid (1), byp_dest (REG_AW) and byp_data (DATA_W).
  - byp_valid = HOLD && entry.reg_we.
  - byp_dest and byp_data come from the entry.
  - These let the operand select forward a pending write to reg_sr1_out/reg_sr2_out.
- When undefined, these ports do not exist. Issue logic must stall on a destination hazard.

Test Plan:
- Reset release with in_valid=0 -> cc_nzp=010, rf_we=0, in_ready=1, br_taken=0, cc_err=0.
- Accept result=8'hF4, flags 100, dest=3, reg_we=1, set_cc=1, rf_ready=1 -> next cycle rf_we=1, waddr=3, wdata=F4; following cycle cc_nzp=100.
- Same stimulus with rf_ready=0 for 3 cycles -> in_ready=0, rf_we=1 with stable data held 3 cycles; retire on the cycle rf_ready=1; a second valid input is accepted that same cycle.
- cc_nzp=001, branch mask=001, target=6'h2A -> br_taken pulses 1 cycle with br_target=2A. Mask=110 -> br_taken stays 0.
- Result=8'h00 with flags 011, set_cc=1 -> cc_nzp=010, cc_err=1 and stays 1 until reset.
- Assert rst_n=0 while in HOLD with rf_ready=0 -> rf_we drops immediately; no write occurs after release; cc_nzp=010.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the ALU: one-entry holding register that retires into the
// register file, the N/Z/P condition code and branch resolution. Optional macro: ALU_WB_BYPASS_EN.
module alu_writeback_stage #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 6,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_neg,
   input  logic              in_zero,
   input  logic              in_pos,
   input  logic [REG_AW-1:0] in_dest,
   input  logic              in_reg_we,
   input  logic              in_set_cc,
   input  logic              in_is_br,
   input  logic [2:0]        in_br_mask,
   input  logic [PC_W-1:0]   in_br_target,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic              rf_ready,
   output logic [2:0]        cc_nzp,
   output logic              br_taken,
   output logic [PC_W-1:0]   br_target,
   output logic              cc_err
`ifdef ALU_WB_BYPASS_EN
   ,
   output logic              byp_valid,
   output logic [REG_AW-1:0] byp_dest,
   output logic [DATA_W-1:0] byp_data
`endif
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state;
   logic [DATA_W-1:0]   result_p0;
   logic [2:0]          flags_p0;
   logic [REG_AW-1:0]   dest_p0;
   logic                reg_we_p0;
   logic                set_cc_p0;
   logic                is_br_p0;
   logic [2:0]          br_mask_p0;
   logic [PC_W-1:0]     br_target_p0;

   logic vld_p0;
   logic retire;
   logic accept;
   logic take;

   function automatic logic is_onehot(input logic [2:0] f);
      return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
   endfunction

   // Malformed ALU flags fall back to a code derived from the result itself.
   function automatic logic [2:0] cc_from(input logic [DATA_W-1:0] r, input logic [2:0] f);
      if (is_onehot(f))
         return f;
      return {r[DATA_W-1], (r == '0), (!r[DATA_W-1] && (r != '0))};
   endfunction

   assign vld_p0   = (state == HOLD);
   assign retire   = vld_p0 && (!reg_we_p0 || rf_ready);
   assign in_ready = (state == IDLE) || retire;
   assign accept   = in_valid && in_ready;
   assign take     = retire && is_br_p0 && |(br_mask_p0 & cc_nzp);

   assign rf_we    = vld_p0 && reg_we_p0;
   assign rf_waddr = dest_p0;
   assign rf_wdata = result_p0;

`ifdef ALU_WB_BYPASS_EN
   assign byp_valid = vld_p0 && reg_we_p0;
   assign byp_dest  = dest_p0;
   assign byp_data  = result_p0;
`endif

   // Stage p0: holding entry (data only, qualified by state)
   always_ff @(posedge clk) begin
      if (accept) begin
         result_p0    <= in_result;
         flags_p0     <= {in_neg, in_zero, in_pos};
         dest_p0      <= in_dest;
         reg_we_p0    <= in_reg_we;
         set_cc_p0    <= in_set_cc;
         is_br_p0     <= in_is_br;
         br_mask_p0   <= in_br_mask;
         br_target_p0 <= in_br_target;
      end
   end

   // Stage p1: control state, condition code and branch outcome
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cc_nzp    <= 3'b010;
         cc_err    <= 1'b0;
         br_taken  <= 1'b0;
         br_target <= '0;
      end else begin
         br_taken <= take;
         if (take)
            br_target <= br_target_p0;
         if (retire && set_cc_p0) begin
            cc_nzp <= cc_from(result_p0, flags_p0);
            if (!is_onehot(flags_p0))
               cc_err <= 1'b1;
         end
         case (state)
            IDLE:    if (accept) state <= HOLD;
            HOLD:    if (retire && !accept) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus a randomized
// run against a transaction-level queue model of the stage.
module tb_alu_writeback_stage;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_result = '0;
   logic       in_neg = 1'b0, in_zero = 1'b0, in_pos = 1'b0;
   logic [2:0] in_dest = '0;
   logic       in_reg_we = 1'b0, in_set_cc = 1'b0, in_is_br = 1'b0;
   logic [2:0] in_br_mask = '0;
   logic [5:0] in_br_target = '0;
   logic       rf_we;
   logic [2:0] rf_waddr;
   logic [7:0] rf_wdata;
   logic       rf_ready = 1'b1;
   logic [2:0] cc_nzp;
   logic       br_taken;
   logic [5:0] br_target;
   logic       cc_err;
`ifdef ALU_WB_BYPASS_EN
   logic       byp_valid;
   logic [2:0] byp_dest;
   logic [7:0] byp_data;
`endif

   int tests_run = 0;
   int fails = 0;

   alu_writeback_stage #(.DATA_W(8), .PC_W(6), .REG_AW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_neg(in_neg), .in_zero(in_zero), .in_pos(in_pos),
      .in_dest(in_dest), .in_reg_we(in_reg_we), .in_set_cc(in_set_cc),
      .in_is_br(in_is_br), .in_br_mask(in_br_mask), .in_br_target(in_br_target),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
      .cc_nzp(cc_nzp), .br_taken(br_taken), .br_target(br_target), .cc_err(cc_err)
`ifdef ALU_WB_BYPASS_EN
      , .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_data(byp_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] result;
      logic [2:0] flags;
      logic [2:0] dest;
      logic       reg_we;
      logic       set_cc;
      logic       is_br;
      logic [2:0] mask;
      logic [5:0] target;
   } ent_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] r, input logic [2:0] f, input logic [2:0] d,
                        input logic we, input logic scc, input logic br, input logic [2:0] m,
                        input logic [5:0] t);
      in_valid = v; in_result = r; {in_neg, in_zero, in_pos} = f; in_dest = d;
      in_reg_we = we; in_set_cc = scc; in_is_br = br; in_br_mask = m; in_br_target = t;
   endtask

   task automatic do_reset();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      rf_ready = 1'b1;
      rst_n = 1'b0;
      tick(); tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (cc_nzp !== 3'b010) begin fails++; $display("FAIL reset_cc: got %b want 010", cc_nzp); end
      tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
      tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tests_run++; if (br_taken !== 1'b0) begin fails++; $display("FAIL reset_br_taken: got %b want 0", br_taken); end
      tests_run++; if (cc_err !== 1'b0) begin fails++; $display("FAIL reset_cc_err: got %b want 0", cc_err); end
   endtask

   task automatic test_writeback();
      @(negedge clk);
      drive(1'b1, 8'hF4, 3'b100, 3'd3, 1'b1, 1'b1, 1'b0, 3'b000, 6'h00);
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tests_run++; if (rf_we !== 1'b1) begin fails++; $display("FAIL wb_rf_we: got %b want 1", rf_we); end
      tests_run++; if (rf_waddr !== 3'd3) begin fails++; $display("FAIL wb_waddr: got %0d want 3", rf_waddr); end
      tests_run++; if (rf_wdata !== 8'hF4) begin fails++; $display("FAIL wb_wdata: got %h want f4", rf_wdata); end
      tests_run++; if (cc_nzp !== 3'b010) begin fails++; $display("FAIL wb_cc_before: got %b want 010", cc_nzp); end
      tick();
      tests_run++; if (cc_nzp !== 3'b100) begin fails++; $display("FAIL wb_cc_after: got %b want 100", cc_nzp); end
      tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL wb_rf_we_idle: got %b want 0", rf_we); end
   endtask

   task automatic test_back_to_back();
      rf_ready = 1'b0;
      drive(1'b1, 8'hF4, 3'b100, 3'd3, 1'b1, 1'b1, 1'b0, 3'b000, 6'h00);
      tick();
      drive(1'b1, 8'h05, 3'b001, 3'd5, 1'b1, 1'b1, 1'b0, 3'b000, 6'h00);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
         tests_run++; if (rf_we !== 1'b1) begin fails++; $display("FAIL stall_rf_we[%0d]: got %b want 1", i, rf_we); end
         tests_run++; if ({rf_waddr, rf_wdata} !== {3'd3, 8'hF4}) begin fails++; $display("FAIL stall_data[%0d]: got %0d/%h want 3/f4", i, rf_waddr, rf_wdata); end
         tick();
      end
      rf_ready = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL retire_in_ready: got %b want 1", in_ready); end
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tests_run++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 8'h05}) begin fails++; $display("FAIL second_entry: got %b/%0d/%h want 1/5/05", rf_we, rf_waddr, rf_wdata); end
      tests_run++; if (cc_nzp !== 3'b100) begin fails++; $display("FAIL b2b_cc1: got %b want 100", cc_nzp); end
      tick();
      tests_run++; if (cc_nzp !== 3'b001) begin fails++; $display("FAIL b2b_cc2: got %b want 001", cc_nzp); end
   endtask

   task automatic test_branch();
      drive(1'b1, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 3'b001, 6'h2A);
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tests_run++; if (br_taken !== 1'b0) begin fails++; $display("FAIL br_early: got %b want 0", br_taken); end
      tick();
      tests_run++; if ({br_taken, br_target} !== {1'b1, 6'h2A}) begin fails++; $display("FAIL br_taken: got %b/%h want 1/2a", br_taken, br_target); end
      tick();
      tests_run++; if (br_taken !== 1'b0) begin fails++; $display("FAIL br_pulse_len: got %b want 0", br_taken); end
      drive(1'b1, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 3'b110, 6'h15);
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tick();
      tests_run++; if (br_taken !== 1'b0) begin fails++; $display("FAIL br_not_taken: got %b want 0", br_taken); end
      tick();
      tests_run++; if (br_taken !== 1'b0) begin fails++; $display("FAIL br_not_taken2: got %b want 0", br_taken); end
   endtask

   task automatic test_cc_err();
      drive(1'b1, 8'h00, 3'b011, 3'd1, 1'b0, 1'b1, 1'b0, 3'b000, 6'h00);
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tick();
      tests_run++; if (cc_nzp !== 3'b010) begin fails++; $display("FAIL ccerr_cc: got %b want 010", cc_nzp); end
      tests_run++; if (cc_err !== 1'b1) begin fails++; $display("FAIL ccerr_set: got %b want 1", cc_err); end
      drive(1'b1, 8'h81, 3'b100, 3'd1, 1'b0, 1'b1, 1'b0, 3'b000, 6'h00);
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tick();
      tests_run++; if ({cc_nzp, cc_err} !== {3'b100, 1'b1}) begin fails++; $display("FAIL ccerr_sticky: got %b/%b want 100/1", cc_nzp, cc_err); end
   endtask

   task automatic test_reset_mid_hold();
      rf_ready = 1'b0;
      drive(1'b1, 8'h77, 3'b001, 3'd2, 1'b1, 1'b1, 1'b0, 3'b000, 6'h00);
      tick();
      drive(1'b0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
      tests_run++; if (rf_we !== 1'b1) begin fails++; $display("FAIL hold_rf_we: got %b want 1", rf_we); end
      rst_n = 1'b0;
      #1;
      tests_run++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_async_rf_we: got %b want 0", rf_we); end
      tests_run++; if ({cc_nzp, cc_err} !== {3'b010, 1'b0}) begin fails++; $display("FAIL rst_async_cc: got %b/%b want 010/0", cc_nzp, cc_err); end
      tick();
      @(negedge clk);
      rf_ready = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++; if ({rf_we, cc_nzp} !== {1'b0, 3'b010}) begin fails++; $display("FAIL post_rst[%0d]: got %b/%b want 0/010", i, rf_we, cc_nzp); end
      end
   endtask

   task automatic test_random();
      ent_t       q[$];
      ent_t       e;
      logic [2:0] m_cc;
      logic       m_err, m_br, m_ready, m_retire, m_acc;
      logic [5:0] m_tgt;
      do_reset();
      m_cc = 3'b010; m_err = 1'b0; m_br = 1'b0; m_tgt = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         e.result = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         e.flags  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : (3'b001 << $urandom_range(0, 2));
         e.dest   = 3'($urandom_range(0, 7));
         e.reg_we = 1'($urandom);
         e.set_cc = 1'($urandom);
         e.is_br  = 1'($urandom);
         e.mask   = 3'($urandom_range(0, 7));
         e.target = 6'($urandom);
         drive(1'($urandom_range(0, 3) != 0), e.result, e.flags, e.dest, e.reg_we, e.set_cc,
               e.is_br, e.mask, e.target);
         rf_ready = ($urandom_range(0, 3) != 0);
         #1;
         m_ready = (q.size() == 0) || !q[0].reg_we || rf_ready;
         tests_run++; if (in_ready !== m_ready) begin fails++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready, m_ready); end
         tests_run++; if (rf_we !== (q.size() != 0 && q[0].reg_we)) begin fails++; $display("FAIL rnd_rf_we@%0d: got %b", cyc, rf_we); end
         if (q.size() != 0 && q[0].reg_we) begin
            tests_run++; if ({rf_waddr, rf_wdata} !== {q[0].dest, q[0].result}) begin fails++; $display("FAIL rnd_wdata@%0d: got %0d/%h want %0d/%h", cyc, rf_waddr, rf_wdata, q[0].dest, q[0].result); end
         end
         tests_run++; if (cc_nzp !== m_cc) begin fails++; $display("FAIL rnd_cc@%0d: got %b want %b", cyc, cc_nzp, m_cc); end
         tests_run++; if (cc_err !== m_err) begin fails++; $display("FAIL rnd_cc_err@%0d: got %b want %b", cyc, cc_err, m_err); end
         tests_run++; if ({br_taken, br_target} !== {m_br, m_tgt}) begin fails++; $display("FAIL rnd_br@%0d: got %b/%h want %b/%h", cyc, br_taken, br_target, m_br, m_tgt); end
         @(posedge clk);
         m_retire = (q.size() != 0) && (!q[0].reg_we || rf_ready);
         m_acc    = in_valid && m_ready;
         m_br     = 1'b0;
         if (m_retire) begin
            if (q[0].is_br && (q[0].mask & m_cc) != 3'b000) begin
               m_br = 1'b1;
               m_tgt = q[0].target;
            end
            if (q[0].set_cc) begin
               if ($countones(q[0].flags) == 1) begin
                  m_cc = q[0].flags;
               end else begin
                  m_cc = {$signed(q[0].result) < 0, q[0].result == 8'h00, $signed(q[0].result) > 0};
                  m_err = 1'b1;
               end
            end
            void'(q.pop_front());
         end
         if (m_acc)
            q.push_back(e);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_writeback();
      test_back_to_back();
      test_branch();
      test_cc_err();
      test_reset_mid_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
